// File: rtl/rr_arb_pkg.sv
// Shared types and width helpers for the round-robin grant sequencer and its
// masked priority encoder.
package rr_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, POP} rr_state_t;

  // Index width for N requesters; never collapses to zero bits.
  function automatic int pick_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter width; MAX_HOLD = 0 (no timeout) still gets a 1-bit counter.
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Request-queue / resource-grant bundle between the queue head, the owners
// and the grant sequencer.
interface rr_grant_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] req_vec;
  logic         req_valid;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         pop;
  logic         timeout;
  logic         busy;

  modport master (
    output req_vec, req_valid, done,
    input  gnt, gnt_valid, pop, timeout, busy
  );

  modport slave (
    input  req_vec, req_valid, done,
    output gnt, gnt_valid, pop, timeout, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational masked priority encoder: first set bit of mask scanning
// upward from ptr+1 with wrap-around.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = pick_idx_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Scan farthest-to-nearest so the nearest set bit after ptr is written last.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (mask[PW'(j)]) idx = PW'(j);
    end
  end

  assign onehot = (|mask) ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Drains the head entry of the request queue by granting each set bit in
// round-robin order, then pulses pop to dequeue it.
module rr_grant_sequencer
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 rst,
  rr_grant_sequencer_if.slave bus
);

  localparam int PW = pick_idx_w(N);
  localparam int HW = hold_cnt_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  rr_state_t     state_q;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  gnt_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] cur_q;
  logic [HW-1:0] hold_q;
  logic          pop_q;
  logic          timeout_q;

  logic [N-1:0]  pending_n;
  logic [N-1:0]  pick_mask;
  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] pick_ptr;
  logic [PW-1:0] pick_idx;
  logic          rel_done;
  logic          rel_timeout;

  assign rel_done    = |(bus.done & gnt_q);
  assign rel_timeout = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);
  assign pending_n   = pending_q & ~gnt_q;

  // One encoder serves both the initial pick from the new head and the
  // follow-on pick from the remaining bits, scanning after the current owner.
  assign pick_mask = (state_q == IDLE) ? bus.req_vec : pending_n;
  assign pick_ptr  = (state_q == IDLE) ? ptr_q : cur_q;

  rr_pick #(.N(N)) u_pick (
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      gnt_q     <= '0;
      ptr_q     <= PW'(N - 1);
      cur_q     <= '0;
      hold_q    <= '0;
      pop_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pop_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && (|bus.req_vec)) begin
            state_q   <= GRANT;
            pending_q <= bus.req_vec;
            gnt_q     <= pick_onehot;
            cur_q     <= pick_idx;
            hold_q    <= '0;
          end
        end
        GRANT: begin
          // The queue already discarded the entry: drop everything, no pop.
          if (!bus.req_valid) begin
            state_q   <= IDLE;
            pending_q <= '0;
            gnt_q     <= '0;
            hold_q    <= '0;
          end else if (rel_done || rel_timeout) begin
            ptr_q     <= cur_q;
            hold_q    <= '0;
            timeout_q <= !rel_done;
            if (|pending_n) begin
              pending_q <= pending_n;
              gnt_q     <= pick_onehot;
              cur_q     <= pick_idx;
            end else begin
              state_q   <= POP;
              pending_q <= '0;
              gnt_q     <= '0;
              pop_q     <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        POP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.pop       = pop_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed vector table plus randomized run against a grant-order model for
// rr_grant_sequencer with N=4, MAX_HOLD=4.
module tb_rr_grant_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_grant_sequencer_if #(.N(N)) bus ();

  rr_grant_sequencer #(.N(N), .MAX_HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] req;
    logic         valid;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         pop;
    logic         tmo;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [N-1:0] r, input logic v, input logic [N-1:0] d,
                              input logic [N-1:0] g, input logic p, input logic t, input logic b);
    vec_t e;
    e.req = r; e.valid = v; e.done = d;
    e.gnt = g; e.pop = p; e.tmo = t; e.busy = b;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] g, input logic p,
                            input logic t, input logic b);
    check({tag, ".gnt"},       int'(bus.gnt),       int'(g));
    check({tag, ".gnt_valid"}, int'(bus.gnt_valid), int'(|g));
    check({tag, ".pop"},       int'(bus.pop),       int'(p));
    check({tag, ".timeout"},   int'(bus.timeout),   int'(t));
    check({tag, ".busy"},      int'(bus.busy),      int'(b));
    if (bus.pop && (bus.gnt != '0)) check({tag, ".pop_with_gnt"}, 1, 0);
    if (!$onehot0(bus.gnt))         check({tag, ".onehot"}, int'(bus.gnt), 0);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic v, input logic [N-1:0] d);
    bus.req_vec   = r;
    bus.req_valid = v;
    bus.done      = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: on latching an entry, the whole service order is fixed
  // up front as a list of requester indices starting after the last owner.
  int order[$];
  int m_last;
  int m_held;
  bit m_popping;
  bit m_to;

  function automatic void model_reset();
    order.delete();
    m_last    = N - 1;
    m_held    = 0;
    m_popping = 1'b0;
    m_to      = 1'b0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input logic v, input logic [N-1:0] d);
    int cur;
    int rv;
    int dv;
    rv   = int'(r);
    dv   = int'(d);
    m_to = 1'b0;
    if (m_popping) begin
      m_popping = 1'b0;
    end else if (order.size() == 0) begin
      if (v && rv != 0) begin
        for (int k = 1; k <= N; k++)
          if (((rv >> ((m_last + k) % N)) & 1) == 1) order.push_back((m_last + k) % N);
        m_held = 0;
      end
    end else if (!v) begin
      order.delete();
    end else begin
      cur = order[0];
      if ((((dv >> cur) & 1) == 1) || (m_held == HOLD - 1)) begin
        m_to   = (((dv >> cur) & 1) == 0);
        m_last = cur;
        void'(order.pop_front());
        m_held = 0;
        if (order.size() == 0) m_popping = 1'b1;
      end else begin
        m_held++;
      end
    end
  endfunction

  function automatic logic [N-1:0] model_gnt();
    return (order.size() > 0) ? (N'(1) << order[0]) : '0;
  endfunction

  initial begin
    int pops;
    pops = 0;

    //   req      v     done     gnt      pop   tmo   busy
    // drain 1011 from reset pointer
    add(4'b1011, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b1011, 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1);
    add(4'b1011, 1'b1, 4'b0010, 4'b1000, 1'b0, 1'b0, 1'b1);
    add(4'b1011, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // pointer carry: 0010 leaves ptr=1, then 0011 wraps to requester 0
    add(4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1);
    add(4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1);
    add(4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(4'b0011, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b0011, 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1);
    add(4'b0011, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1);
    // timeout: 0100 held exactly 4 cycles, then timeout with pop
    add(4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // abort: ptr=2 so 0110 grants requester 1 first, then req_valid drops
    add(4'b0110, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1);
    add(4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // stray done; matching done coinciding with the hold limit wins
    add(4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b0001, 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b0001, 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b0001, 1'b1, 4'b1110, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
    add(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    // back-to-back entries 0001 then 0100
    add(4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1);

    rst = 1'b1;
    drive('0, 1'b0, '0);
    tick();
    tick();
    check_outs("reset", '0, 1'b0, 1'b0, 1'b0);
    $display("reset: gnt=%b pop=%b timeout=%b busy=%b", bus.gnt, bus.pop, bus.timeout, bus.busy);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].valid, tbl[i].done);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].pop, tbl[i].tmo, tbl[i].busy);
      $display("vec %0d: req=%b valid=%b done=%b -> gnt=%b pop=%b timeout=%b busy=%b",
               i, tbl[i].req, tbl[i].valid, tbl[i].done,
               bus.gnt, bus.pop, bus.timeout, bus.busy);
    end

    // Asynchronous reset mid-grant clears outputs without waiting for an edge.
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", '0, 1'b0, 1'b0, 1'b0);
    $display("async reset mid-grant: gnt=%b busy=%b", bus.gnt, bus.busy);
    drive('0, 1'b0, '0);
    tick();
    rst = 1'b0;

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      logic [N-1:0] d;
      logic         v;
      r = N'($urandom);
      v = ($urandom_range(0, 15) != 0);
      if ((order.size() > 0) && ($urandom_range(0, 3) == 0)) d = N'(1) << order[0];
      else if ($urandom_range(0, 3) == 0)                    d = N'($urandom);
      else                                                    d = '0;
      drive(r, v, d);
      model_edge(r, v, d);
      tick();
      check_outs($sformatf("rand%0d", c), model_gnt(), m_popping, m_to, m_popping || (order.size() > 0));
      if (m_popping) begin
        pops++;
        $display("rand entry %0d popped at cycle %0d (last owner %0d, timeout=%b)",
                 pops, c, m_last, bus.timeout);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
